// File: rtl/uart_pkg.sv
// Shared definitions for the 32-bit-word UART: FSM encodings, APB register map, STATUS layout.
// UART_TX_PARITY_EN adds the PARITY state between the last data bit and the stop bit.
package uart_pkg;

  localparam int DATA_BITS = 32;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic [3:0] ADDR_TXDATA = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;
  localparam int STAT_CNT_MSB = 15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd3
  } tx_state_e;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO holding words waiting for the serializer.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/uart_word_tx.sv
// APB-fed UART transmitter: queued 32-bit words are sent as start, 32 data bits LSB first, stop.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1042,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        tx,
  output logic        txDone,
  output logic        TxBusy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  tx_state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_tx, r_done, r_busy, r_ovf;
  logic [31:0]          r_prdata;
  logic                 w_tx_nxt, w_bit_end, w_pop;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity, w_parity_nxt;
`endif

  logic                 w_access, w_wr_data, w_rd, w_rd_status, w_drop;
  logic [DATA_BITS-1:0] w_fifo_dout;
  logic                 w_full, w_empty;
  logic [CW-1:0]        w_count;
  logic [31:0]          w_status;
  logic                 w_unused;

  assign w_access    = PSEL & PENABLE;
  assign w_wr_data   = w_access & PWRITE & (PADDR[3:2] == ADDR_TXDATA[3:2]);
  assign w_rd        = w_access & ~PWRITE;
  assign w_rd_status = w_rd & (PADDR[3:2] == ADDR_STATUS[3:2]);
  assign w_drop      = w_wr_data & w_full & ~w_pop;
  assign w_unused    = ^{PADDR[31:4], PADDR[1:0]};

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (PCLK),
    .i_rst   (PRESET),
    .i_push  (w_wr_data),
    .i_pop   (w_pop),
    .i_din   (PWDATA),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_status                            = '0;
    w_status[STAT_CNT_MSB:STAT_CNT_LSB] = 8'(w_count);
    w_status[STAT_OVF]                  = r_ovf;
    w_status[STAT_BUSY]                 = r_busy;
    w_status[STAT_FULL]                 = w_full;
    w_status[STAT_EMPTY]                = w_empty;
  end

  // Overflow is captured into PRDATA on the same edge that clears it.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_prdata <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_rd) r_prdata <= w_rd_status ? w_status : '0;
      if (w_drop)           r_ovf <= 1'b1;
      else if (w_rd_status) r_ovf <= 1'b0;
    end
  end

  assign w_bit_end = (r_cnt == CNT_LAST);

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
    w_pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_parity_nxt = r_parity;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_dout;
          w_idx_nxt   = '0;
`ifdef UART_TX_PARITY_EN
          w_parity_nxt = even_parity(w_fifo_dout);
`endif
          w_state_nxt = ST_START;
        end
      end
      ST_START: if (w_bit_end) w_state_nxt = ST_DATA;
      ST_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = {1'b0, r_shift[DATA_BITS-1:1]};
          w_idx_nxt   = r_idx + 1'b1;
          if (r_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (w_bit_end) w_state_nxt = ST_STOP;
`endif
      ST_STOP: if (w_bit_end) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase

    w_cnt_nxt = (r_state == ST_IDLE || w_bit_end) ? '0 : r_cnt + 1'b1;

    // tx is registered from the next state so the line level changes exactly on the state edge.
    case (w_state_nxt)
      ST_START:  w_tx_nxt = START_BIT;
      ST_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_tx_nxt = w_parity_nxt;
`endif
      default:   w_tx_nxt = STOP_BIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= STOP_BIT;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (r_state == ST_STOP) && (r_cnt == CNT_DONE);
`ifdef UART_TX_PARITY_EN
      r_parity <= w_parity_nxt;
`endif
    end
  end

  assign PRDATA = r_prdata;
  assign PREADY = 1'b1;
  assign tx     = r_tx;
  assign txDone = r_done;
  assign TxBusy = r_busy;

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4; honours UART_TX_PARITY_EN.
module tb_uart_word_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 35;
`else
  localparam int NB = 34;
`endif
  localparam logic [31:0] A_TXDATA = 32'h0;
  localparam logic [31:0] A_STATUS = 32'h4;

  logic        PCLK    = 1'b0;
  logic        PRESET  = 1'b1;
  logic        PSEL    = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE  = 1'b0;
  logic [31:0] PADDR   = '0;
  logic [31:0] PWDATA  = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        tx;
  logic        txDone;
  logic        TxBusy;

  int n_checks = 0;
  int n_fail   = 0;

  uart_word_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .tx      (tx),
    .txDone  (txDone),
    .TxBusy  (TxBusy)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
    data = PRDATA;
  endtask

  // Leaves the caller on the negedge of the first start-bit cycle.
  task automatic wait_start(input string tag);
    int n = 0;
    while (tx !== 1'b0 && n < 40) begin
      @(negedge PCLK);
      n++;
    end
    check(tag, {31'd0, tx}, 32'd0);
  endtask

  // Assumes the current negedge is the first start-bit cycle; ends on the last stop-bit cycle.
  task automatic check_frame(input string tag, input logic [31:0] word);
    logic [34:0] bits = '0;
    int          busy_cyc = 0;
    int          dones = 0;
    logic        done_last = 1'b0;
    for (int c = 0; c < NB * CPB; c++) begin
      if (c != 0) @(negedge PCLK);
      busy_cyc += int'(TxBusy);
      dones    += int'(txDone);
      if (c % CPB == CPB / 2) bits[c / CPB] = tx;
      if (c == NB * CPB - 1) done_last = txDone;
    end
    check({tag, "_start"}, {31'd0, bits[0]}, 32'd0);
    check({tag, "_data"}, bits[32:1], word);
`ifdef UART_TX_PARITY_EN
    check({tag, "_parity"}, {31'd0, bits[33]}, {31'd0, ^word});
`endif
    check({tag, "_stop"}, {31'd0, bits[NB-1]}, 32'd1);
    check({tag, "_busy_cycles"}, busy_cyc, NB * CPB);
    check({tag, "_done_pulses"}, dones, 32'd1);
    check({tag, "_done_last"}, {31'd0, done_last}, 32'd1);
  endtask

  task automatic check_gap(input string tag);
    @(negedge PCLK);
    check({tag, "_idle"}, {31'd0, TxBusy}, 32'd0);
    @(negedge PCLK);
    check({tag, "_busy"}, {31'd0, TxBusy}, 32'd1);
    check({tag, "_tx_low"}, {31'd0, tx}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 20000 cycles");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] mid_word;
    int          dones;
    int          lows;

    // Reset state.
    PRESET = 1'b1;
    repeat (3) @(negedge PCLK);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, TxBusy}, 32'd0);
    check("rst_done", {31'd0, txDone}, 32'd0);
    check("rst_prdata", PRDATA, 32'h0);
    check("pready", {31'd0, PREADY}, 32'd1);
    PRESET = 1'b0;
    apb_read(A_STATUS, rd);
    check("rst_status", rd, 32'h0000_0001);
    apb_read(A_TXDATA, rd);
    check("txdata_read_zero", rd, 32'h0);
    apb_write(A_STATUS, 32'hFFFF_FFFF);
    @(negedge PCLK);
    check("status_write_no_frame", {31'd0, TxBusy}, 32'd0);
    apb_read(A_STATUS, rd);
    check("status_write_ignored", rd, 32'h0000_0001);

    // Single word: tx falls one edge after the write edge.
    apb_write(A_TXDATA, 32'hA5A5_0F0F);
    check("single_tx_before", {31'd0, tx}, 32'd1);
    @(negedge PCLK);
    check("single_tx_latency", {31'd0, tx}, 32'd0);
    check("single_busy_rise", {31'd0, TxBusy}, 32'd1);
    check_frame("single", 32'hA5A5_0F0F);
    @(negedge PCLK);
    check("single_end_busy", {31'd0, TxBusy}, 32'd0);
    check("single_end_tx", {31'd0, tx}, 32'd1);

    // Back-to-back frames with a single idle cycle between them.
    fork
      begin
        apb_write(A_TXDATA, 32'h0000_0001);
        apb_write(A_TXDATA, 32'hFFFF_FFFF);
        apb_write(A_TXDATA, 32'h8000_0000);
      end
      begin
        wait_start("b2b_first_start");
        check_frame("b2b0", 32'h0000_0001);
        check_gap("b2b_gap0");
        check_frame("b2b1", 32'hFFFF_FFFF);
        check_gap("b2b_gap1");
        check_frame("b2b2", 32'h8000_0000);
      end
    join
    @(negedge PCLK);
    check("b2b_end_busy", {31'd0, TxBusy}, 32'd0);

    // Overflow: one word popped, four queued, sixth dropped.
    for (int i = 0; i < 6; i++) apb_write(A_TXDATA, 32'h11 * (i + 1));
    apb_read(A_STATUS, rd);
    check("ovf_status_first", rd, 32'h0000_040E);
    apb_read(A_STATUS, rd);
    check("ovf_status_second", rd, 32'h0000_0406);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    apb_read(A_STATUS, rd);
    check("ovf_flushed", rd, 32'h0000_0001);

    // Reset in the middle of data bit 10.
    mid_word = 32'h1234_5678;
    apb_write(A_TXDATA, mid_word);
    wait_start("mid_start");
    repeat (CPB + 10 * CPB + CPB / 2) @(negedge PCLK);
    check("mid_bit10", {31'd0, tx}, {31'd0, mid_word[10]});
    PRESET = 1'b1;
    @(negedge PCLK);
    check("mid_rst_tx", {31'd0, tx}, 32'd1);
    check("mid_rst_busy", {31'd0, TxBusy}, 32'd0);
    PRESET = 1'b0;
    dones = 0;
    lows  = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge PCLK);
      dones += int'(txDone);
      lows  += int'(tx == 1'b0);
    end
    check("mid_no_done", dones, 32'd0);
    check("mid_line_idle", lows, 32'd0);
    apb_read(A_STATUS, rd);
    check("mid_fifo_empty", rd, 32'h0000_0001);

`ifdef UART_TX_PARITY_EN
    // Parity bit: odd popcount gives 1, even gives 0.
    apb_write(A_TXDATA, 32'h0000_0007);
    wait_start("par7_start");
    check_frame("par7", 32'h0000_0007);
    apb_write(A_TXDATA, 32'h0000_0003);
    wait_start("par3_start");
    check_frame("par3", 32'h0000_0003);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
